dw_weight_cache: RTL and testbench

DW_WEIGHT_CACHE -- requirements
Module: dw_weight_cache

---
 rtl/dw_weight_cache.sv | 184 ++++++++++++++++++
 tb/tb_dw_weight_cache.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dw_weight_cache.sv
// dw_weight_cache: two-bank 128-bit weight cache, filled from the DW arbiter and read by the consumer.
// Define DW_CACHE_BEAT_CHECK_EN to flag fills whose received beat count differs from dw_count_o.
module dw_weight_cache #(
  parameter  int ADDR_W = 16,
  parameter  int DEPTH  = 64,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [16:0]       load_count_i,
  output logic              load_ready_o,
  output logic              load_err_o,
  output logic              dw_req_o,
  output logic [ADDR_W-1:0] dw_base_o,
  output logic [16:0]       dw_count_o,
  input  logic              dw_grant_i,
  input  logic              dw_valid_i,
  input  logic [127:0]      dw_data_i,
  input  logic              dw_done_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [127:0]      rd_data_o,
  output logic              bank_ready_o,
  input  logic              bank_release_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2
  } state_e;

  localparam logic [16:0] DEPTH_17 = 17'(DEPTH);

  state_e              state_q;
  logic                dw_req_q;
  logic [ADDR_W-1:0]   dw_base_q;
  logic [16:0]         dw_count_q;
  logic                load_err_q;
  logic [127:0]        rd_data_q;
  logic [1:0]          full_q;
  logic [1:0]          full_d;
  logic [AW:0]         stored_cnt_q [2];
  logic                wr_bank_q;
  logic                rd_bank_q;
  logic [AW:0]         wr_ptr_q;
  logic [AW:0]         fill_cnt_d;
  logic [127:0]        mem_q [2][DEPTH];

  logic load_acc;
  logic count_bad;
  logic beat_wr;
  logic fill_done;
  logic rel_acc;
  logic rd_hit;

`ifdef DW_CACHE_BEAT_CHECK_EN
  logic [16:0] rx_cnt_q;
  logic [16:0] rx_total_d;
  logic        cnt_mis;
`endif

  assign load_ready_o = (state_q == ST_IDLE) && !full_q[wr_bank_q];
  assign bank_ready_o = full_q[rd_bank_q];
  assign load_err_o   = load_err_q;
  assign dw_req_o     = dw_req_q;
  assign dw_base_o    = dw_base_q;
  assign dw_count_o   = dw_count_q;
  assign rd_data_o    = rd_data_q;

  // Decode of handshakes, fill progress and per-bank full flags for this cycle.
  always_comb begin
    load_acc  = load_start_i && load_ready_o;
    count_bad = (load_count_i == 17'd0) || (load_count_i > DEPTH_17);
    // wr_ptr_q saturates at DEPTH, so its MSB marks a full bank and later beats are dropped
    beat_wr    = (state_q == ST_FILL) && dw_valid_i && !wr_ptr_q[AW];
    fill_done  = (state_q == ST_FILL) && dw_done_i;
    fill_cnt_d = wr_ptr_q + {{AW{1'b0}}, beat_wr};
    rel_acc    = bank_release_i && full_q[rd_bank_q];
    rd_hit     = full_q[rd_bank_q] && ({1'b0, rd_addr_i} < stored_cnt_q[rd_bank_q]);
    full_d     = full_q;
    for (int b = 0; b < 2; b++) begin
      if (fill_done && (wr_bank_q == 1'(b))) begin
        full_d[b] = 1'b1;
      end else if (rel_acc && (rd_bank_q == 1'(b))) begin
        full_d[b] = 1'b0;
      end else begin
        full_d[b] = full_q[b];
      end
    end
`ifdef DW_CACHE_BEAT_CHECK_EN
    if (&rx_cnt_q) begin
      rx_total_d = rx_cnt_q;
    end else begin
      rx_total_d = rx_cnt_q + {16'd0, dw_valid_i};
    end
    cnt_mis = (rx_total_d != dw_count_q);
`endif
  end

  // Bank storage write port; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      mem_q[wr_bank_q][wr_ptr_q[AW-1:0]] <= dw_data_i;
    end
  end

  // Fill FSM, bank bookkeeping and registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      dw_req_q        <= 1'b0;
      dw_base_q       <= '0;
      dw_count_q      <= '0;
      load_err_q      <= 1'b0;
      rd_data_q       <= '0;
      full_q          <= '0;
      stored_cnt_q[0] <= '0;
      stored_cnt_q[1] <= '0;
      wr_bank_q       <= 1'b0;
      rd_bank_q       <= 1'b0;
      wr_ptr_q        <= '0;
`ifdef DW_CACHE_BEAT_CHECK_EN
      rx_cnt_q        <= '0;
`endif
    end else begin
      load_err_q <= 1'b0;
      full_q     <= full_d;
      if (rel_acc) begin
        rd_bank_q <= ~rd_bank_q;
      end
      if (rd_en_i) begin
        rd_data_q <= rd_hit ? mem_q[rd_bank_q][rd_addr_i] : '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (load_acc) begin
            if (count_bad) begin
              load_err_q <= 1'b1;
            end else begin
              dw_base_q  <= load_base_i;
              dw_count_q <= load_count_i;
              wr_ptr_q   <= '0;
`ifdef DW_CACHE_BEAT_CHECK_EN
              rx_cnt_q   <= '0;
`endif
              dw_req_q   <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (dw_grant_i) begin
            dw_req_q <= 1'b0;
            state_q  <= ST_FILL;
          end
        end
        ST_FILL: begin
          wr_ptr_q <= fill_cnt_d;
`ifdef DW_CACHE_BEAT_CHECK_EN
          rx_cnt_q <= rx_total_d;
`endif
          if (fill_done) begin
            stored_cnt_q[wr_bank_q] <= fill_cnt_d;
            wr_bank_q               <= ~wr_bank_q;
            state_q                 <= ST_IDLE;
`ifdef DW_CACHE_BEAT_CHECK_EN
            if (cnt_mis) begin
              load_err_q <= 1'b1;
            end
`endif
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          dw_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dw_weight_cache.sv
// Directed self-checking bench for dw_weight_cache (default DEPTH=64, ADDR_W=16).
module tb_dw_weight_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_start;
  logic [15:0]  load_base;
  logic [16:0]  load_count;
  logic         load_ready;
  logic         load_err;
  logic         dw_req;
  logic [15:0]  dw_base;
  logic [16:0]  dw_count;
  logic         dw_grant;
  logic         dw_valid;
  logic [127:0] dw_data;
  logic         dw_done;
  logic         rd_en;
  logic [5:0]   rd_addr;
  logic [127:0] rd_data;
  logic         bank_ready;
  logic         bank_release;

  int n_total = 0;
  int n_bad   = 0;

  dw_weight_cache dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_i(load_start), .load_base_i(load_base), .load_count_i(load_count),
    .load_ready_o(load_ready), .load_err_o(load_err),
    .dw_req_o(dw_req), .dw_base_o(dw_base), .dw_count_o(dw_count),
    .dw_grant_i(dw_grant), .dw_valid_i(dw_valid), .dw_data_i(dw_data), .dw_done_i(dw_done),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .bank_ready_o(bank_ready), .bank_release_i(bank_release)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] beat(input int k);
    return {32'hDEAD0000 ^ 32'(k), 32'h600D0000 + 32'(k), 32'(k * 3 + 1), 32'hB0000000 | 32'(k)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load_start = 1'b0; load_base = 16'd0; load_count = 17'd0;
    dw_grant = 1'b0; dw_valid = 1'b0; dw_data = 128'd0; dw_done = 1'b0;
    rd_en = 1'b0; rd_addr = 6'd0; bank_release = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [127:0] exp);
    rd_en = 1'b1;
    rd_addr = 6'(a);
    tick();
    rd_en = 1'b0;
    check_eq(tag, rd_data, exp);
  endtask

  task automatic do_fill(input logic [15:0] base, input int cnt, input int nbeats,
                         input int seed, input logic rel);
    load_start = 1'b1; load_base = base; load_count = 17'(cnt);
    tick();
    load_start = 1'b0;
    check_eq("fill_req_on", 128'(dw_req), 128'd1);
    dw_grant = 1'b1;
    tick();
    dw_grant = 1'b0;
    check_eq("fill_req_off", 128'(dw_req), 128'd0);
    for (int i = 0; i < nbeats; i++) begin
      dw_valid = 1'b1;
      dw_data = beat(seed + i);
      tick();
    end
    dw_valid = 1'b0;
    dw_done = 1'b1;
    bank_release = rel;
    tick();
    dw_done = 1'b0;
    bank_release = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int req_cyc;
    logic seen;

    // Reset values
    do_reset();
    check_eq("rst_load_ready", 128'(load_ready), 128'd1);
    check_eq("rst_bank_ready", 128'(bank_ready), 128'd0);
    check_eq("rst_dw_req", 128'(dw_req), 128'd0);
    check_eq("rst_dw_base", 128'(dw_base), 128'd0);
    check_eq("rst_dw_count", 128'(dw_count), 128'd0);
    check_eq("rst_load_err", 128'(load_err), 128'd0);
    check_eq("rst_rd_data", rd_data, 128'd0);

    // Basic 4-beat fill with 3-cycle request and stray beats during REQ
    load_start = 1'b1; load_base = 16'h0100; load_count = 17'd4;
    tick();
    load_start = 1'b0; load_base = 16'hFFFF; load_count = 17'd9;
    req_cyc = 0;
    for (int c = 0; c < 2; c++) begin
      if (dw_req) req_cyc++;
      dw_valid = 1'b1; dw_data = 128'hBAD;
      tick();
    end
    dw_valid = 1'b0;
    if (dw_req) req_cyc++;
    check_eq("req_base", 128'(dw_base), 128'h0100);
    check_eq("req_count", 128'(dw_count), 128'd4);
    dw_grant = 1'b1;
    tick();
    dw_grant = 1'b0;
    check_eq("req_drop", 128'(dw_req), 128'd0);
    check_eq("req_cycles", 128'(req_cyc), 128'd3);
    for (int i = 0; i < 4; i++) begin
      dw_valid = 1'b1; dw_data = beat(i);
      tick();
    end
    dw_valid = 1'b0;
    check_eq("fill_base_stable", 128'(dw_base), 128'h0100);
    check_eq("fill_bank_not_ready", 128'(bank_ready), 128'd0);
    dw_done = 1'b1;
    tick();
    dw_done = 1'b0;
    check_eq("done_bank_ready", 128'(bank_ready), 128'd1);
    check_eq("done_load_ready", 128'(load_ready), 128'd1);
    for (int a = 0; a < 4; a++) rd_chk("rd_beat", a, beat(a));
    rd_addr = 6'd1;
    tick();
    check_eq("rd_hold", rd_data, beat(3));
    rd_chk("rd_above_cnt", 5, 128'd0);

    // Two fills with no release leave no free bank
    do_reset();
    do_fill(16'h0200, 8, 8, 100, 1'b0);
    do_fill(16'h0300, 8, 8, 200, 1'b0);
    check_eq("two_full_load_ready", 128'(load_ready), 128'd0);
    check_eq("two_full_bank_ready", 128'(bank_ready), 128'd1);
    load_start = 1'b1; load_count = 17'd8;
    tick();
    load_start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      seen = seen | dw_req | load_err;
      tick();
    end
    check_eq("third_ignored", 128'(seen), 128'd0);
    rd_chk("bank0_last", 7, beat(107));
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check_eq("rel1_bank_ready", 128'(bank_ready), 128'd1);
    check_eq("rel1_load_ready", 128'(load_ready), 128'd1);
    rd_chk("bank1_first", 0, beat(200));
    bank_release = 1'b1;
    tick();
    bank_release = 1'b0;
    check_eq("rel2_bank_ready", 128'(bank_ready), 128'd0);
    rd_chk("empty_read", 0, 128'd0);

    // Release and done in the same cycle
    do_reset();
    do_fill(16'h0010, 4, 4, 300, 1'b0);
    do_fill(16'h0020, 4, 4, 400, 1'b1);
    check_eq("same_cyc_bank_ready", 128'(bank_ready), 128'd1);
    check_eq("same_cyc_load_ready", 128'(load_ready), 128'd1);
    rd_chk("same_cyc_rd_bank1", 0, beat(400));

    // Illegal counts, then DEPTH boundary with overrun beats
    do_reset();
    load_start = 1'b1; load_count = 17'd0;
    tick();
    load_start = 1'b0;
    check_eq("cnt0_err", 128'(load_err), 128'd1);
    check_eq("cnt0_req", 128'(dw_req), 128'd0);
    tick();
    check_eq("cnt0_err_pulse", 128'(load_err), 128'd0);
    load_start = 1'b1; load_count = 17'd65;
    tick();
    load_start = 1'b0;
    check_eq("cnt65_err", 128'(load_err), 128'd1);
    check_eq("cnt65_req", 128'(dw_req), 128'd0);
    check_eq("cnt65_load_ready", 128'(load_ready), 128'd1);
    tick();
    check_eq("cnt65_err_pulse", 128'(load_err), 128'd0);
    do_fill(16'h0040, 64, 66, 500, 1'b0);
    rd_chk("depth_first", 0, beat(500));
    rd_chk("depth_last", 63, beat(563));

    // Asynchronous reset in the middle of a fill into the second bank
    load_start = 1'b1; load_base = 16'h0ABC; load_count = 17'd64;
    tick();
    load_start = 1'b0;
    dw_grant = 1'b1;
    tick();
    dw_grant = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dw_valid = 1'b1; dw_data = beat(700 + i);
      tick();
    end
    dw_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    check_eq("abort_dw_req", 128'(dw_req), 128'd0);
    check_eq("abort_dw_base", 128'(dw_base), 128'd0);
    check_eq("abort_dw_count", 128'(dw_count), 128'd0);
    check_eq("abort_load_err", 128'(load_err), 128'd0);
    check_eq("abort_rd_data", rd_data, 128'd0);
    check_eq("abort_bank_ready", 128'(bank_ready), 128'd0);
    check_eq("abort_load_ready", 128'(load_ready), 128'd1);
    rd_chk("abort_read", 0, 128'd0);

    // Short fill: 3 beats against a count of 4
    do_reset();
    do_fill(16'h0060, 4, 3, 600, 1'b0);
`ifdef DW_CACHE_BEAT_CHECK_EN
    check_eq("short_err", 128'(load_err), 128'd1);
`else
    check_eq("short_err", 128'(load_err), 128'd0);
`endif
    tick();
    check_eq("short_err_clear", 128'(load_err), 128'd0);
    check_eq("short_bank_ready", 128'(bank_ready), 128'd1);
    rd_chk("short_last", 2, beat(602));
    rd_chk("short_beyond", 3, 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
